ex_stage: RTL
=============

# ex_stage

Execute stage of the 5-stage MIPS pipeline, between ID and MEM_Access. It registers the ID/EX bundle, runs the ALU, computes load/store effective addresses and branch targets, and resolves conditional branches. It produces the EX/MEM pipeline register consumed by MEM_Access, plus a one-cycle taken-branch pulse that IF and ID use for redirect and flush.

## Interface
Parameters:
- DATA_W, 32, datapath width; ALU, address and IR widths all equal DATA_W.

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  reset; synchronous, active-high.
- ID_EX_Type_i  input  3  instruction type from definitions_pkg: RR_ALU=000, RM_ALU=001, LOAD=010, STORE=011, BRANCH=100, HALT=101, BUBBLE=110.
- ID_EX_IR_i  input  32  instruction word; opcode is IR[31:26].
- ID_EX_NPC_i  input  32  PC+1 of this instruction (word address).
- ID_EX_A_i  input  32  rs operand.
- ID_EX_B_i  input  32  rt operand.
- ID_EX_Imm_i  input  32  immediate, already sign-extended by ID.
- halted_flag_i  input  1  global halt from WB; freezes this stage.
- EX_MEM_Type_o  output  3  registered type to MEM.
- EX_MEM_IR_o  output  32  registered IR.
- EX_MEM_ALUOut_o  output  32  ALU result, effective address or branch target.
- EX_MEM_B_o  output  32  store data (rt passthrough).
- EX_MEM_Cond_o  output  1  branch condition result.
- taken_branch_o  output  1  registered; high for exactly the cycle after a taken branch leaves EX.
- branch_pc_o  output  32  registered branch target; valid while taken_branch_o=1.

## Operation
- **Opcodes (IR[31:26]):** ADD 000000, SUB 000001, AND 000010, OR 000011, SLT 000100, MUL 000101, LW 001000, SW 001001, ADDI 001010, SUBI 001011, SLTI 001100, BNEQZ 001101, BEQZ 001110, HLT 111111.
- **RR_ALU:** ALUOut = A op B.
  - ADD/SUB wrap modulo 2^32.
  - SLT is signed; result is 32'd1 or 32'd0.
  - MUL gives the low 32 bits of the signed product.
  - An unknown opcode gives ALUOut = 32'hxxxx_xxxx in simulation; synthesis may return 0.
- **RM_ALU:** ALUOut = A op Imm for ADDI/SUBI/SLTI, with the same width and sign rules as RR_ALU.
- **LOAD/STORE:** ALUOut = A + Imm (wrapping). EX_MEM_B_o = B.
- **BRANCH:**
  - ALUOut = NPC + Imm.
  - Cond = (A==0) for BEQZ, (A!=0) for BNEQZ.
  - Taken: taken_branch_o=1 and branch_pc_o=ALUOut at the next edge.
- **HALT:** passes through with ALUOut=0, Cond=0.
- **BUBBLE:** passes through as BUBBLE with ALUOut=0, Cond=0.
- **EX_MEM_B_o:** carries ID_EX_B_i for every type.
- **Squash:** while taken_branch_o=1, the instruction being captured is wrong-path.
  - It is latched as Type=BUBBLE, IR=0, ALUOut=0, Cond=0.
  - taken_branch_o is not re-asserted by it, even if it is itself a taken branch.
  - IF/ID flush the remaining wrong-path instruction themselves.
- **Freeze:** while halted_flag_i=1, every output register holds its value, including taken_branch_o. No new instruction is captured.
- **Reset (rst=1 at an edge):** Type=BUBBLE; IR, ALUOut, B, branch_pc = 0; Cond=0; taken_branch_o=0. Reset overrides freeze and squash.
- Reset asserted mid-branch clears any pending taken_branch_o at that edge.

## Timing
- Latency is 1 cycle: ID/EX inputs sampled at edge N appear on the EX/MEM outputs after edge N.
- Throughput is one instruction per cycle. There is no stall input.
- taken_branch_o rises after the edge that captures a taken branch and falls after the following edge. Two consecutive cycles are impossible because of the squash rule.
- A HALT entering EX does not freeze this stage. Only halted_flag_i does, which WB raises later. Instructions behind the HALT still flow until then.
- halted_flag_i and rst in the same cycle: reset wins.
- halted_flag_i and a taken branch in the same cycle: the branch is not captured and taken_branch_o holds its prior value.

## Test plan
- **ALU ops:** ADD A=7, B=5 -> ALUOut=12, Type=RR_ALU.
  - SUB A=0, B=1 -> 32'hFFFF_FFFF.
  - SLT A=32'hFFFF_FFFF, B=1 -> 1.
  - MUL A=-3, B=4 -> 32'hFFFF_FFF4.
- **Immediate/memory:** ADDI A=10, Imm=-2 -> 8. LW A=32'h100, Imm=4 -> ALUOut=32'h104. SW B=32'hDEAD_BEEF -> EX_MEM_B_o=32'hDEAD_BEEF.
- **Branch resolution:**
  - BEQZ, A=0, NPC=20, Imm=5 -> Cond=1, ALUOut=25, taken_branch_o=1 for one cycle, branch_pc_o=25.
  - BNEQZ, A=0 -> Cond=0, taken_branch_o stays 0.
- **Squash:** a taken BEQZ followed by ADD, then SUB -> the ADD appears as BUBBLE with ALUOut=0, and the SUB passes normally. A taken branch in the squash slot does not pulse taken_branch_o.
- **Freeze:** assert halted_flag_i for 3 cycles while inputs change -> all outputs are constant. Deassert -> the next instruction is captured on the following edge.
- **Reset:** assert rst with taken_branch_o=1 and halted_flag_i=1 -> outputs go to Type=BUBBLE, all zero, taken_branch_o=0 at the next edge.

Source files
------------

// File: rtl/ex_stage.sv
// Execute stage: ALU, effective address, branch target and branch resolution.
// Registers the EX/MEM bundle and a one-cycle taken-branch redirect pulse.
module ex_stage #(
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [2:0]        ID_EX_Type_i,
    input  logic [DATA_W-1:0] ID_EX_IR_i,
    input  logic [DATA_W-1:0] ID_EX_NPC_i,
    input  logic [DATA_W-1:0] ID_EX_A_i,
    input  logic [DATA_W-1:0] ID_EX_B_i,
    input  logic [DATA_W-1:0] ID_EX_Imm_i,
    input  logic              halted_flag_i,
    output logic [2:0]        EX_MEM_Type_o,
    output logic [DATA_W-1:0] EX_MEM_IR_o,
    output logic [DATA_W-1:0] EX_MEM_ALUOut_o,
    output logic [DATA_W-1:0] EX_MEM_B_o,
    output logic              EX_MEM_Cond_o,
    output logic              taken_branch_o,
    output logic [DATA_W-1:0] branch_pc_o
);

    localparam logic [2:0] T_RR_ALU = 3'b000;
    localparam logic [2:0] T_RM_ALU = 3'b001;
    localparam logic [2:0] T_LOAD   = 3'b010;
    localparam logic [2:0] T_STORE  = 3'b011;
    localparam logic [2:0] T_BRANCH = 3'b100;
    localparam logic [2:0] T_BUBBLE = 3'b110;

    localparam logic [5:0] OP_ADD   = 6'b000000;
    localparam logic [5:0] OP_SUB   = 6'b000001;
    localparam logic [5:0] OP_AND   = 6'b000010;
    localparam logic [5:0] OP_OR    = 6'b000011;
    localparam logic [5:0] OP_SLT   = 6'b000100;
    localparam logic [5:0] OP_MUL   = 6'b000101;
    localparam logic [5:0] OP_ADDI  = 6'b001010;
    localparam logic [5:0] OP_SUBI  = 6'b001011;
    localparam logic [5:0] OP_SLTI  = 6'b001100;
    localparam logic [5:0] OP_BNEQZ = 6'b001101;
    localparam logic [5:0] OP_BEQZ  = 6'b001110;

    logic [5:0]        op;
    logic [DATA_W-1:0] alu_res;
    logic              cond;

    logic [2:0]        type_q, type_d;
    logic [DATA_W-1:0] ir_q, ir_d;
    logic [DATA_W-1:0] alu_q, alu_d;
    logic [DATA_W-1:0] b_q, b_d;
    logic              cond_q, cond_d;
    logic              taken_q, taken_d;
    logic [DATA_W-1:0] bpc_q, bpc_d;

    assign op = ID_EX_IR_i[DATA_W-1 -: 6];

    always_comb begin
        alu_res = '0;
        cond    = 1'b0;
        case (ID_EX_Type_i)
            T_RR_ALU: begin
                case (op)
                    OP_ADD:  alu_res = ID_EX_A_i + ID_EX_B_i;
                    OP_SUB:  alu_res = ID_EX_A_i - ID_EX_B_i;
                    OP_AND:  alu_res = ID_EX_A_i & ID_EX_B_i;
                    OP_OR:   alu_res = ID_EX_A_i | ID_EX_B_i;
                    OP_SLT:  alu_res = {{(DATA_W-1){1'b0}},
                                        $signed(ID_EX_A_i) < $signed(ID_EX_B_i)};
                    // Low half of a product is identical for signed and unsigned.
                    OP_MUL:  alu_res = ID_EX_A_i * ID_EX_B_i;
                    default: alu_res = 'x;
                endcase
            end
            T_RM_ALU: begin
                case (op)
                    OP_ADDI: alu_res = ID_EX_A_i + ID_EX_Imm_i;
                    OP_SUBI: alu_res = ID_EX_A_i - ID_EX_Imm_i;
                    OP_SLTI: alu_res = {{(DATA_W-1){1'b0}},
                                        $signed(ID_EX_A_i) < $signed(ID_EX_Imm_i)};
                    default: alu_res = 'x;
                endcase
            end
            T_LOAD, T_STORE: alu_res = ID_EX_A_i + ID_EX_Imm_i;
            T_BRANCH: begin
                alu_res = ID_EX_NPC_i + ID_EX_Imm_i;
                if (op == OP_BEQZ)
                    cond = (ID_EX_A_i == '0);
                else if (op == OP_BNEQZ)
                    cond = (ID_EX_A_i != '0);
            end
            default: alu_res = '0;
        endcase
    end

    always_comb begin
        type_d  = type_q;
        ir_d    = ir_q;
        alu_d   = alu_q;
        b_d     = b_q;
        cond_d  = cond_q;
        taken_d = taken_q;
        bpc_d   = bpc_q;
        if (!halted_flag_i) begin
            b_d = ID_EX_B_i;
            if (taken_q) begin
                // Wrong-path slot behind a taken branch.
                type_d  = T_BUBBLE;
                ir_d    = '0;
                alu_d   = '0;
                cond_d  = 1'b0;
                taken_d = 1'b0;
            end else begin
                type_d  = ID_EX_Type_i;
                ir_d    = ID_EX_IR_i;
                alu_d   = alu_res;
                cond_d  = cond;
                taken_d = (ID_EX_Type_i == T_BRANCH) && cond;
                if (taken_d)
                    bpc_d = alu_res;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            type_q  <= T_BUBBLE;
            ir_q    <= '0;
            alu_q   <= '0;
            b_q     <= '0;
            cond_q  <= 1'b0;
            taken_q <= 1'b0;
            bpc_q   <= '0;
        end else begin
            type_q  <= type_d;
            ir_q    <= ir_d;
            alu_q   <= alu_d;
            b_q     <= b_d;
            cond_q  <= cond_d;
            taken_q <= taken_d;
            bpc_q   <= bpc_d;
        end
    end

    assign EX_MEM_Type_o   = type_q;
    assign EX_MEM_IR_o     = ir_q;
    assign EX_MEM_ALUOut_o = alu_q;
    assign EX_MEM_B_o      = b_q;
    assign EX_MEM_Cond_o   = cond_q;
    assign taken_branch_o  = taken_q;
    assign branch_pc_o     = bpc_q;

endmodule
